// File: rtl/fp_fmt_pkg.sv
// rtl/fp_fmt_pkg.sv - narrow-float format defaults, field helpers and class enum
// Shared by the unpacker and the scalar precision converter.
package fp_fmt_pkg;

  localparam int EXP_W_DEF  = 4;
  localparam int FRAC_W_DEF = 3;

  typedef enum logic [2:0] {
    FP_ZERO,
    FP_SUB,
    FP_NORM,
    FP_INF,
    FP_NAN
  } fp_class_t;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic logic [31:0] fp_exp_field(input logic [31:0] e, input int frac_w,
                                               input int exp_w);
    return (e >> frac_w) & ((32'd1 << exp_w) - 32'd1);
  endfunction

  function automatic logic [31:0] fp_frac_field(input logic [31:0] e, input int frac_w);
    return e & ((32'd1 << frac_w) - 32'd1);
  endfunction

  function automatic logic fp_sign_field(input logic [31:0] e, input int frac_w,
                                         input int exp_w);
    return e[frac_w + exp_w];
  endfunction

endpackage

// File: rtl/fp_classify.sv
// rtl/fp_classify.sv - combinational element classifier (zero/sub/norm/inf/nan)
module fp_classify
  import fp_fmt_pkg::*;
#(
  parameter int EXP_W  = EXP_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic [EXP_W+FRAC_W:0] elem_i,
  output fp_class_t             cls_o
);

  localparam logic [31:0] EXP_MAX = (32'd1 << EXP_W) - 32'd1;

  logic [31:0] elem32;
  logic [31:0] exp_f;
  logic [31:0] frac_f;

  assign elem32 = 32'(elem_i);
  assign exp_f  = fp_exp_field(elem32, FRAC_W, EXP_W);
  assign frac_f = fp_frac_field(elem32, FRAC_W);

  always_comb begin
    cls_o = FP_NORM;
    if (exp_f == EXP_MAX) begin
      cls_o = (frac_f == 32'd0) ? FP_INF : FP_NAN;
    end else if (exp_f == 32'd0) begin
      cls_o = (frac_f == 32'd0) ? FP_ZERO : FP_SUB;
    end
  end

endmodule

// File: rtl/fp_elem_unpacker.sv
// rtl/fp_elem_unpacker.sv - holds one packed word and streams its elements in lane order
module fp_elem_unpacker
  import fp_fmt_pkg::*;
#(
  parameter int EXP_WIDTH_IN     = EXP_W_DEF,
  parameter int FRAC_WIDTH_IN    = FRAC_W_DEF,
  parameter int ELEMENT_WIDTH_IN = EXP_WIDTH_IN + FRAC_WIDTH_IN + 1,
  parameter int LANES            = 8,
  parameter int CNT_W            = $clog2(LANES + 1),
  parameter int IDX_W            = $clog2(LANES)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES*ELEMENT_WIDTH_IN-1:0] in_data,
  input  logic [CNT_W-1:0]              in_count,
  input  logic                          in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ELEMENT_WIDTH_IN-1:0]   out_elem,
  output logic [IDX_W-1:0]              out_index,
  output logic                          out_last,
  output logic                          out_is_nan,
  output logic                          out_is_inf,
  output logic                          drop_last
);

  localparam int EW = ELEMENT_WIDTH_IN;

  typedef enum logic {S_IDLE, S_DRAIN} state_t;

  state_t                  state_q;
  logic [IDX_W-1:0]        idx_q;
  logic [CNT_W-1:0]        rem_q;
  logic [LANES*EW-1:0]     held_q;
  logic                    last_q;
  logic                    drop_q;

  logic [CNT_W-1:0]        eff_d;
  logic                    accept;
  logic                    out_hs;
  logic                    final_elem;
  fp_class_t               cls;

  assign eff_d      = (in_count > CNT_W'(LANES)) ? CNT_W'(LANES) : in_count;
  assign final_elem = (rem_q == CNT_W'(1));
  assign out_valid  = (state_q == S_DRAIN);
  // Ready on the final handshake cycle lets the next word follow with no bubble.
  assign in_ready   = (state_q == S_IDLE) || (final_elem && out_ready);
  assign accept     = in_valid && in_ready;
  assign out_hs     = out_valid && out_ready;

  assign out_elem   = held_q[idx_q*EW +: EW];
  assign out_index  = idx_q;
  assign out_last   = out_valid && last_q && final_elem;
  assign drop_last  = drop_q;

  fp_classify #(
    .EXP_W  (EXP_WIDTH_IN),
    .FRAC_W (FRAC_WIDTH_IN)
  ) u_classify (
    .elem_i (out_elem),
    .cls_o  (cls)
  );

  assign out_is_nan = (cls == FP_NAN);
  assign out_is_inf = (cls == FP_INF);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      rem_q   <= '0;
      held_q  <= '0;
      last_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      if (out_hs) begin
        if (final_elem) begin
          state_q <= S_IDLE;
          idx_q   <= '0;
          rem_q   <= '0;
        end else begin
          idx_q <= idx_q + IDX_W'(1);
          rem_q <= rem_q - CNT_W'(1);
        end
      end
      // A new word overrides the drain bookkeeping of the one just finished.
      if (accept) begin
        if (eff_d != '0) begin
          state_q <= S_DRAIN;
          idx_q   <= '0;
          rem_q   <= eff_d;
          held_q  <= in_data;
          last_q  <= in_last;
        end else if (in_last) begin
          drop_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_elem_unpacker.sv
// tb/tb_fp_elem_unpacker.sv - self-checking bench for fp_elem_unpacker
module tb_fp_elem_unpacker;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [3:0]  in_count;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_elem;
  logic [2:0]  out_index;
  logic        out_last;
  logic        out_is_nan;
  logic        out_is_inf;
  logic        drop_last;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] e;
    int         idx;
    bit         last;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  fp_elem_unpacker dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_count   (in_count),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_elem   (out_elem),
    .out_index  (out_index),
    .out_last   (out_last),
    .out_is_nan (out_is_nan),
    .out_is_inf (out_is_inf),
    .drop_last  (drop_last)
  );

  function automatic logic [7:0] lane(input logic [63:0] w, input int k);
    return w[k*8 +: 8];
  endfunction

  function automatic bit is_nan(input logic [7:0] e);
    return (e[6:3] == 4'hF) && (e[2:0] != 3'd0);
  endfunction

  function automatic bit is_inf(input logic [7:0] e);
    return (e[6:3] == 4'hF) && (e[2:0] == 3'd0);
  endfunction

  task automatic accept_word(input logic [63:0] d, input logic [3:0] c, input logic l);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_count = c;
    in_last  = l;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_ready: in_ready=%b required 1", in_ready);
    end
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_count = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); #1;
    n_checks++;
    if ({out_valid, out_index, out_last, drop_last, in_ready} !== {1'b0, 3'd0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b idx=%0d last=%b drop=%b ready=%b required 0 0 0 0 1",
               out_valid, out_index, out_last, drop_last, in_ready);
    end
  endtask

  task automatic test_full_word();
    logic [63:0] w;
    for (int k = 0; k < 8; k++) w[k*8 +: 8] = 8'h38 + 8'(8*k);
    accept_word(w, 4'd8, 1'b1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b1 || out_elem !== lane(w, k) || out_index !== 3'(k) ||
          out_last !== (k == 7) || in_ready !== (k == 7)) begin
        n_fail++;
        $display("FAIL full_word[%0d]: v=%b e=%h i=%0d l=%b r=%b required 1 %h %0d %b %b",
                 k, out_valid, out_elem, out_index, out_last, in_ready, lane(w, k), k, k == 7, k == 7);
      end
    end
    @(negedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL full_word_idle: out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] a, b;
    exp_t exp_l[5];
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    for (int k = 0; k < 3; k++) exp_l[k] = '{lane(a, k), k, 1'b0};
    for (int k = 0; k < 2; k++) exp_l[3 + k] = '{lane(b, k), k, k == 1};
    accept_word(a, 4'd3, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = (i == 2);
      in_data  = b;
      in_count = 4'd2;
      in_last  = 1'b1;
      #1;
      n_checks++;
      if (out_valid !== 1'b1 || out_elem !== exp_l[i].e || out_index !== 3'(exp_l[i].idx) ||
          out_last !== exp_l[i].last) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: v=%b e=%h i=%0d l=%b required 1 %h %0d %b",
                 i, out_valid, out_elem, out_index, out_last, exp_l[i].e, exp_l[i].idx, exp_l[i].last);
      end
    end
    @(negedge clk); in_valid = 1'b0; #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL back_to_back_idle: out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_stall();
    logic [63:0] w;
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int hs = 0;
    w = {$urandom, $urandom};
    accept_word(w, 4'd4, 1'b1);
    for (int c = 0; c < 24 && hs < 4; c++) begin
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = pat[c % 4];
      #1;
      n_checks++;
      if (out_valid !== 1'b1 || out_elem !== lane(w, hs) || out_index !== 3'(hs) ||
          out_last !== (hs == 3)) begin
        n_fail++;
        $display("FAIL stall[%0d]: v=%b e=%h i=%0d l=%b required 1 %h %0d %b",
                 c, out_valid, out_elem, out_index, out_last, lane(w, hs), hs, hs == 3);
      end
      if (out_ready && out_valid) hs++;
    end
    n_checks++;
    if (hs != 4) begin
      n_fail++;
      $display("FAIL stall_handshakes: got %0d required 4", hs);
    end
    @(negedge clk); out_ready = 1'b1;
  endtask

  task automatic test_class();
    logic [63:0] w;
    for (int k = 0; k < 8; k++) w[k*8 +: 8] = 8'h38 + 8'(k);
    w[2*8 +: 8] = 8'h7F;
    w[3*8 +: 8] = 8'hF8;
    w[4*8 +: 8] = 8'h00;
    accept_word(w, 4'd8, 1'b0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      n_checks++;
      if (out_elem !== lane(w, k) || out_is_nan !== (k == 2) || out_is_inf !== (k == 3)) begin
        n_fail++;
        $display("FAIL class[%0d]: e=%h nan=%b inf=%b required %h %b %b",
                 k, out_elem, out_is_nan, out_is_inf, lane(w, k), k == 2, k == 3);
      end
    end
  endtask

  task automatic test_zero_count();
    logic [63:0] w;
    accept_word(64'h1234_5678_9abc_def0, 4'd0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || drop_last !== 1'b1 || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL zero_count[%0d]: v=%b drop=%b ready=%b required 0 1 1",
                 c, out_valid, drop_last, in_ready);
      end
    end
    w = {$urandom, $urandom};
    accept_word(w, 4'd12, 1'b0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b1 || out_elem !== lane(w, k) || out_index !== 3'(k) ||
          out_last !== 1'b0 || drop_last !== 1'b1) begin
        n_fail++;
        $display("FAIL overcount[%0d]: v=%b e=%h i=%0d l=%b drop=%b required 1 %h %0d 0 1",
                 k, out_valid, out_elem, out_index, out_last, drop_last, lane(w, k), k);
      end
    end
    @(negedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL overcount_idle: out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_mid_reset();
    logic [63:0] w, w2;
    w  = {$urandom, $urandom};
    w2 = {$urandom, $urandom};
    accept_word(w, 4'd8, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
    end
    n_checks++;
    if (out_index !== 3'd3) begin
      n_fail++;
      $display("FAIL mid_reset_pos: idx=%0d required 3", out_index);
    end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    n_checks++;
    if (out_valid !== 1'b0 || drop_last !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset: v=%b drop=%b ready=%b required 0 0 1", out_valid, drop_last, in_ready);
    end
    accept_word(w2, 4'd2, 1'b1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b1 || out_elem !== lane(w2, k) || out_index !== 3'(k) ||
          out_last !== (k == 1)) begin
        n_fail++;
        $display("FAIL after_reset[%0d]: v=%b e=%h i=%0d l=%b required 1 %h %0d %b",
                 k, out_valid, out_elem, out_index, out_last, lane(w2, k), k, k == 1);
      end
    end
  endtask

  task automatic test_random();
    bit drop_exp = 1'b0;
    bit exp_ready, exp_valid;
    int eff;
    q.delete();
    @(negedge clk);
    for (int c = 0; c < 400 + 64; c++) begin
      if (c > 0) @(negedge clk);
      if (c < 400) begin
        in_valid  = ($urandom % 2) == 0;
        in_data   = {$urandom, $urandom};
        in_count  = 4'($urandom_range(0, 10));
        in_last   = ($urandom % 3) == 0;
        out_ready = ($urandom % 4) != 0;
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      #1;
      exp_valid = (q.size() != 0);
      exp_ready = (q.size() == 0) || (q.size() == 1 && out_ready);
      n_checks++;
      if (in_ready !== exp_ready || out_valid !== exp_valid || drop_last !== drop_exp) begin
        n_fail++;
        $display("FAIL rand_ctrl[%0d]: ready=%b valid=%b drop=%b required %b %b %b",
                 c, in_ready, out_valid, drop_last, exp_ready, exp_valid, drop_exp);
      end
      if (exp_valid) begin
        n_checks++;
        if (out_elem !== q[0].e || out_index !== 3'(q[0].idx) || out_last !== q[0].last ||
            out_is_nan !== is_nan(q[0].e) || out_is_inf !== is_inf(q[0].e)) begin
          n_fail++;
          $display("FAIL rand_data[%0d]: e=%h i=%0d l=%b nan=%b inf=%b required %h %0d %b %b %b",
                   c, out_elem, out_index, out_last, out_is_nan, out_is_inf,
                   q[0].e, q[0].idx, q[0].last, is_nan(q[0].e), is_inf(q[0].e));
        end
        if (out_ready) void'(q.pop_front());
      end
      if (in_valid && exp_ready) begin
        eff = (in_count > 8) ? 8 : int'(in_count);
        if (eff == 0 && in_last) drop_exp = 1'b1;
        for (int k = 0; k < eff; k++) q.push_back('{lane(in_data, k), k, in_last && (k == eff - 1)});
      end
    end
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL rand_drain: %0d elements left required 0", q.size());
    end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_back_to_back();
    test_stall();
    test_class();
    test_zero_count();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
